// File: rtl/mat_serializer.sv
// Captures a packed H x W matrix on a load strobe and streams it out one
// element per valid/ready handshake, row-major, with row/col tags and a last flag.
module mat_serializer #(
    parameter int S = 32,
    parameter int H = 4,
    parameter int W = 1,
    localparam int N  = H * W,
    localparam int RW = (H > 1) ? $clog2(H) : 1,
    localparam int CW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [N*S-1:0] mat,
    output logic [S-1:0]  out_data,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [RW-1:0] ROW_MAX    = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX    = CW'(W - 1);
    localparam logic          FIRST_LAST = (N == 1);

    state_t         state;
    logic [N*S-1:0] shadow;

    logic [RW-1:0]  next_row;
    logic [CW-1:0]  next_col;
    logic           next_last;
    logic [S-1:0]   next_data;

    logic           streaming;
    logic           fire;
    logic           final_fire;
    logic           accept;

    assign streaming  = (state == STREAM);
    assign fire       = streaming && out_ready;
    assign final_fire = fire && out_last;
    // A new matrix fits only when idle or exactly as the last element leaves.
    assign accept     = load && (!streaming || final_fire);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_row  = out_row;
        next_col  = out_col;
        next_data = '0;
        if (out_col == COL_MAX) begin
            next_col = '0;
            next_row = out_row + 1'b1;
        end else begin
            next_col = out_col + 1'b1;
        end
        next_last = (next_row == ROW_MAX) && (next_col == COL_MAX);
        // Past the last element the index would run off the shadow register.
        if (!out_last) begin
            next_data = shadow[(N - 1 - (int'(next_row) * W + int'(next_col))) * S +: S];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow register is reset too, so nothing stale from a
            // previous matrix can leak out after an abandoned stream.
            state     <= IDLE;
            shadow    <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= final_fire;

            if (streaming && load && !final_fire) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                state     <= STREAM;
                shadow    <= mat;
                out_data  <= mat[N*S-1 -: S];
                out_row   <= '0;
                out_col   <= '0;
                out_last  <= FIRST_LAST;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end else if (fire) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_last  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    out_data <= next_data;
                    out_row  <= next_row;
                    out_col  <= next_col;
                    out_last <= next_last;
                end
            end
        end
    end

endmodule
